univ_shift_reg: RTL
===================

Name: univ_shift_reg

Overview:
- Parametrised universal shift register; successor to the fixed single-bit serial-in/serial-out shift register.
- Modes: hold, shift right, shift left, parallel load.
- Serial and parallel outputs; a frame counter flags every WIDTH shifts.
- Sits between serial links and parallel datapaths as a SIPO/PISO/SISO/PIPO building block.

Parameters:
- WIDTH, 8, register width in bits; minimum 2.
- RST_VAL, 0, WIDTH-bit value loaded into the register on reset.
- CNT_W, $clog2(WIDTH), width of shift_cnt; minimum 1.

Ports:
- clk  input  1  clock; all state changes on the rising edge.
- rst  input  1  asynchronous, active-low reset (rst=0 resets immediately, regardless of clk).
- en  input  1  clock enable; 0 = hold all state.
- mode  input  2  00 hold, 01 shift right, 10 shift left, 11 parallel load.
- si_r  input  1  serial input entering the MSB on a right shift.
- si_l  input  1  serial input entering the LSB on a left shift.
- pi  input  WIDTH  parallel load data.
- po  output  WIDTH  register contents (q).
- so_r  output  1  q[0]; serial output for right shift.
- so_l  output  1  q[WIDTH-1]; serial output for left shift.
- shift_cnt  output  CNT_W  shifts completed in the current frame.
- frame_done  output  1  one-cycle pulse when the WIDTH-th shift of a frame completes.

Behaviour:
- Reset (rst=0, async): q=RST_VAL, shift_cnt=0, frame_done=0; po/so_r/so_l follow q. Release is synchronous to the next edge; no shift on the release edge unless en=1 at that edge.
- po, so_r, so_l are combinational from q only; no path from inputs to outputs.
- en=0 or mode=00: q and shift_cnt hold; frame_done=0.
- mode=01 (en=1): q <= {si_r, q[WIDTH-1:1]}.
- mode=10 (en=1): q <= {q[WIDTH-2:0], si_l}.
- mode=11 (en=1): q <= pi; shift_cnt <= 0; frame_done <= 0. A load aborts a partial frame.
- Counter, on any shift edge (mode 01/10, en=1):
  - If shift_cnt==WIDTH-1: shift_cnt <= 0 and frame_done <= 1 at the same edge.
  - Otherwise: shift_cnt increments and frame_done <= 0.
- frame_done is registered and high for exactly one cycle per frame. It stays high on back-to-back frames only when each frame completes at consecutive edges, which is impossible for WIDTH>=2, so the pulse is always isolated.
- Direction change mid-frame (01<->10) does not clear shift_cnt; shifts in either direction count toward the frame.
- Latency: serial bit at si_r is visible at so_r after WIDTH right-shift edges; parallel load is visible on po after 1 edge.
- Reset mid-frame: partial frame discarded; the next frame needs a full WIDTH shifts.

Optional Feature:
- Macro: UNIV_SHIFT_ROTATE_EN.
- Defined: adds input port rot (1 bit). When rot=1 during a shift, the serial input is replaced by the bit shifted out: right q <= {q[0], q[WIDTH-1:1]}, left q <= {q[WIDTH-2:0], q[WIDTH-1]}. The counter and frame_done behave as for normal shifts. rot is ignored in modes 00/11.
- Undefined: no rot port; shifts always take si_r/si_l.

Test Plan:
- Reset, WIDTH=8, RST_VAL=0: drive rst=0 mid-cycle -> po=8'h00, so_r=0, so_l=0, shift_cnt=0, frame_done=0 immediately, without waiting for a clock edge.
- Load: en=1, mode=11, pi=8'hA5 for one edge -> po=8'hA5, so_r=1, so_l=1, shift_cnt=0.
- PISO right: after loading 8'hA5, mode=01, si_r=0 for 8 edges:
  - so_r before each edge = 1,0,1,0,0,1,0,1.
  - After the 8th edge: po=8'h00, shift_cnt=0, frame_done=1 for exactly that one cycle.
- SIPO left with hold: load 8'h00; mode=10 with si_l=1,0,0,1, and one en=0 cycle inserted after the second shift -> po=8'h09, shift_cnt=4, frame_done never high.
- Reset mid-frame: 3 right shifts (shift_cnt=3), then rst=0 between edges -> po=RST_VAL, shift_cnt=0. After release, frame_done first pulses only after 8 further shifts.
- Rotate (UNIV_SHIFT_ROTATE_EN): load 8'h81, rot=1, mode=10:
  - After 1 edge: po=8'h03.
  - After 8 edges total: po=8'h81 and frame_done=1.

Source files
------------

// File: rtl/univ_shift_reg.sv
// Universal shift register: hold / shift right / shift left / parallel load, with a frame counter.
// Optional rotate input enabled by defining UNIV_SHIFT_ROTATE_EN.
module univ_shift_reg #(
  parameter int unsigned       WIDTH   = 8,
  parameter logic [WIDTH-1:0]  RST_VAL = '0,
  parameter int unsigned       CNT_W   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [1:0]       mode,
  input  logic             si_r,
  input  logic             si_l,
`ifdef UNIV_SHIFT_ROTATE_EN
  input  logic             rot,
`endif
  input  logic [WIDTH-1:0] pi,
  output logic [WIDTH-1:0] po,
  output logic             so_r,
  output logic             so_l,
  output logic [CNT_W-1:0] shift_cnt,
  output logic             frame_done
);

  typedef enum logic [1:0] {
    MODE_HOLD = 2'b00,
    MODE_SHR  = 2'b01,
    MODE_SHL  = 2'b10,
    MODE_LOAD = 2'b11
  } mode_e;

  logic [WIDTH-1:0] q, q_next;
  logic [CNT_W-1:0] cnt, cnt_next;
  logic             done, done_next;
  logic             fill_r, fill_l;
  logic             do_shift;

  always_comb begin
    fill_r = si_r;
    fill_l = si_l;
`ifdef UNIV_SHIFT_ROTATE_EN
    // Rotation recirculates the bit leaving the opposite end.
    if (rot) begin
      fill_r = q[0];
      fill_l = q[WIDTH-1];
    end
`endif
  end

  always_comb begin
    q_next    = q;
    cnt_next  = cnt;
    done_next = 1'b0;
    do_shift  = 1'b0;
    if (en) begin
      unique case (mode_e'(mode))
        MODE_HOLD: ;
        MODE_SHR: begin
          q_next   = {fill_r, q[WIDTH-1:1]};
          do_shift = 1'b1;
        end
        MODE_SHL: begin
          q_next   = {q[WIDTH-2:0], fill_l};
          do_shift = 1'b1;
        end
        MODE_LOAD: begin
          q_next   = pi;
          cnt_next = '0;
        end
        default: ;
      endcase
    end
    if (do_shift) begin
      if (cnt == CNT_W'(WIDTH - 1)) begin
        cnt_next  = '0;
        done_next = 1'b1;
      end else begin
        cnt_next = cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      q    <= RST_VAL;
      cnt  <= '0;
      done <= 1'b0;
    end else begin
      q    <= q_next;
      cnt  <= cnt_next;
      done <= done_next;
    end
  end

  assign po         = q;
  assign so_r       = q[0];
  assign so_l       = q[WIDTH-1];
  assign shift_cnt  = cnt;
  assign frame_done = done;

endmodule
